// File: rtl/tx_delay_pulser_ch_pkg.sv
// ============================================================================
//  Module   : tx_delay_pulser_ch_pkg
//  Brief    : Shared constants and FSM encoding for the transmit delay/pulser
//             channel. Default widths match the receive delay-LUT width set.
//  Config   : TX_APOD_MASK_EN (adds a fire-enable bit above the delay word)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tx_delay_pulser_ch_pkg;

   // Default widths, shared with the receive-side delay LUT
   localparam int c_ADDR_WD  = 8;
   localparam int c_DELAY_WD = 12;
   localparam int c_HPER_WD  = 8;
   localparam int c_NCYC_WD  = 4;

   // Extra LUT bit carrying the per-line channel fire enable
`ifdef TX_APOD_MASK_EN
   localparam int c_APOD_BITS = 1;
`else
   localparam int c_APOD_BITS = 0;
`endif

   // Channel FSM encoding
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_DELAY   = 3'd2,
      ST_PULSE_P = 3'd3,
      ST_PULSE_N = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   // Stored LUT word width for a given delay width
   function automatic int lut_width(input int delay_wd);
      return delay_wd + c_APOD_BITS;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tx_delay_pulser_ch_if.sv
// ============================================================================
//  Module   : tx_delay_pulser_ch_if
//  Brief    : Control / LUT-load / pulser-drive bundle of one transmit channel.
//             master = sequencer side, slave = channel side.
//  Config   : TX_APOD_MASK_EN widens lut_din by one bit
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tx_delay_pulser_ch_if
   import tx_delay_pulser_ch_pkg::*;
#(
   parameter int ADDR_WD  = c_ADDR_WD,
   parameter int DELAY_WD = c_DELAY_WD,
   parameter int HPER_WD  = c_HPER_WD,
   parameter int NCYC_WD  = c_NCYC_WD
);
   localparam int LUT_WD = lut_width(DELAY_WD);

   // LUT load port
   logic [ADDR_WD-1:0] lut_addr;
   logic               lut_we;
   logic [LUT_WD-1:0]  lut_din;

   // Fire control
   logic [ADDR_WD-1:0] line_idx;
   logic               start;
   logic               abort;
   logic [HPER_WD-1:0] half_period;
   logic [NCYC_WD-1:0] num_cycles;

   // Pulser drive and status
   logic               pulse_p;
   logic               pulse_n;
   logic               tx_active;
   logic               tx_done;

   modport master (
      output lut_addr, lut_we, lut_din,
      output line_idx, start, abort, half_period, num_cycles,
      input  pulse_p, pulse_n, tx_active, tx_done
   );

   modport slave (
      input  lut_addr, lut_we, lut_din,
      input  line_idx, start, abort, half_period, num_cycles,
      output pulse_p, pulse_n, tx_active, tx_done
   );

endinterface

`default_nettype wire

// File: rtl/tx_delay_lut.sv
// ============================================================================
//  Module   : tx_delay_lut
//  Brief    : Simple dual-port RAM, one write port and one synchronous read
//             port. A same-address read and write in one cycle returns the
//             old word (read-first). Contents are not reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_delay_lut
   import tx_delay_pulser_ch_pkg::*;
#(
   parameter int ADDR_WD = c_ADDR_WD,
   parameter int DATA_WD = c_DELAY_WD
)
(
   input  wire logic               clk,
   input  wire logic               i_we,
   input  wire logic [ADDR_WD-1:0] i_waddr,
   input  wire logic [DATA_WD-1:0] i_wdata,
   input  wire logic               i_re,
   input  wire logic [ADDR_WD-1:0] i_raddr,
   output      logic [DATA_WD-1:0] o_rdata
);

   localparam int c_DEPTH = 1 << ADDR_WD;

   logic [DATA_WD-1:0] r_mem [0:c_DEPTH-1];
   logic [DATA_WD-1:0] r_rdata;

   // Write port: the word lands on the edge where i_we is high
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read port: samples the array before this edge's write, hence read-first
   always_ff @(posedge clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/tx_delay_pulser_ch.sv
// ============================================================================
//  Module   : tx_delay_pulser_ch
//  Brief    : Per-element transmit channel. On start, reads the element's
//             focal delay for the scan line, waits that many clocks, then
//             drives a bipolar burst of num_cycles periods, each half lasting
//             half_period clocks. tx_active / tx_done let the receive chain
//             gate on transmit.
//  Config   : TX_APOD_MASK_EN - LUT MSB is a fire enable; a muted line runs the
//             same timing with pulse_p / pulse_n held low.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_delay_pulser_ch
   import tx_delay_pulser_ch_pkg::*;
#(
   parameter int ADDR_WD  = c_ADDR_WD,
   parameter int DELAY_WD = c_DELAY_WD,
   parameter int HPER_WD  = c_HPER_WD,
   parameter int NCYC_WD  = c_NCYC_WD
)
(
   input wire logic              clk,
   input wire logic              rst_n,
   tx_delay_pulser_ch_if.slave   bus
);

   localparam int LUT_WD = lut_width(DELAY_WD);

   state_t              r_state;
   logic [DELAY_WD-1:0] r_dly_cnt;
   logic [HPER_WD-1:0]  r_hcnt;
   logic [HPER_WD-1:0]  r_half;
   logic [NCYC_WD-1:0]  r_ncyc;
   logic                r_pulse_p;
   logic                r_pulse_n;
   logic                r_tx_active;
   logic                r_tx_done;

   logic                w_fire;
   logic [HPER_WD-1:0]  w_half_eff;
   logic [LUT_WD-1:0]   w_lut_q;
   logic [DELAY_WD-1:0] w_lut_delay;
   logic                w_fire_en;

   // A fire is accepted only from IDLE and never alongside abort. The LUT
   // registers line_idx internally, so no separate line latch is kept.
   assign w_fire      = (r_state == ST_IDLE) && bus.start && !bus.abort;
   assign w_half_eff  = (bus.half_period == '0) ? HPER_WD'(1) : bus.half_period;
   assign w_lut_delay = w_lut_q[DELAY_WD-1:0];

   tx_delay_lut #(
      .ADDR_WD (ADDR_WD),
      .DATA_WD (LUT_WD)
   ) u_lut (
      .clk     (clk),
      .i_we    (bus.lut_we),
      .i_waddr (bus.lut_addr),
      .i_wdata (bus.lut_din),
      .i_re    (w_fire),
      .i_raddr (bus.line_idx),
      .o_rdata (w_lut_q)
   );

`ifdef TX_APOD_MASK_EN
   logic r_fire_en;

   // Latch the per-line fire enable while the delay word is being captured
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fire_en <= 1'b0;
      end else if (r_state == ST_LOAD) begin
         r_fire_en <= w_lut_q[LUT_WD-1];
      end
   end

   assign w_fire_en = r_fire_en;
`else
   assign w_fire_en = 1'b1;
`endif

   // Channel sequencer; outputs are registered images of the current state,
   // so each output lags its state by one clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_dly_cnt   <= '0;
         r_hcnt      <= '0;
         r_half      <= '0;
         r_ncyc      <= '0;
         r_pulse_p   <= 1'b0;
         r_pulse_n   <= 1'b0;
         r_tx_active <= 1'b0;
         r_tx_done   <= 1'b0;
      end else if (bus.abort && (r_state != ST_IDLE)) begin
         // Abort drops everything on this edge and suppresses tx_done
         r_state     <= ST_IDLE;
         r_dly_cnt   <= '0;
         r_hcnt      <= '0;
         r_half      <= '0;
         r_ncyc      <= '0;
         r_pulse_p   <= 1'b0;
         r_pulse_n   <= 1'b0;
         r_tx_active <= 1'b0;
         r_tx_done   <= 1'b0;
      end else begin
         r_tx_active <= (r_state == ST_LOAD) || (r_state == ST_DELAY) ||
                        (r_state == ST_PULSE_P) || (r_state == ST_PULSE_N);
         r_tx_done   <= (r_state == ST_DONE);
         r_pulse_p   <= (r_state == ST_PULSE_P) && w_fire_en;
         r_pulse_n   <= (r_state == ST_PULSE_N) && w_fire_en;

         unique case (r_state)
            ST_IDLE: begin
               if (w_fire) begin
                  r_half  <= w_half_eff;
                  r_ncyc  <= bus.num_cycles;
                  r_state <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               r_dly_cnt <= w_lut_delay;
               r_hcnt    <= r_half;
               if (w_lut_delay != '0) begin
                  r_state <= ST_DELAY;
               end else if (r_ncyc == '0) begin
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_PULSE_P;
               end
            end

            ST_DELAY: begin
               r_dly_cnt <= r_dly_cnt - DELAY_WD'(1);
               if (r_dly_cnt == DELAY_WD'(1)) begin
                  r_hcnt  <= r_half;
                  r_state <= (r_ncyc == '0) ? ST_DONE : ST_PULSE_P;
               end
            end

            ST_PULSE_P: begin
               if (r_hcnt == HPER_WD'(1)) begin
                  r_hcnt  <= r_half;
                  r_state <= ST_PULSE_N;
               end else begin
                  r_hcnt  <= r_hcnt - HPER_WD'(1);
               end
            end

            ST_PULSE_N: begin
               if (r_hcnt == HPER_WD'(1)) begin
                  r_hcnt  <= r_half;
                  r_ncyc  <= r_ncyc - NCYC_WD'(1);
                  r_state <= (r_ncyc == NCYC_WD'(1)) ? ST_DONE : ST_PULSE_P;
               end else begin
                  r_hcnt  <= r_hcnt - HPER_WD'(1);
               end
            end

            ST_DONE: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.pulse_p   = r_pulse_p;
   assign bus.pulse_n   = r_pulse_n;
   assign bus.tx_active = r_tx_active;
   assign bus.tx_done   = r_tx_done;

endmodule

`default_nettype wire

// File: tb/tb_tx_delay_pulser_ch.sv
// ============================================================================
//  Module   : tb_tx_delay_pulser_ch
//  Brief    : Self-checking bench for tx_delay_pulser_ch. Expected waveforms
//             come from closed-form timing of each fire (delay, half period,
//             cycle count) and a bench-side copy of the LUT contents.
//  Config   : TX_APOD_MASK_EN honoured through the package width constants
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_delay_pulser_ch;
   import tx_delay_pulser_ch_pkg::*;

   localparam int AW = c_ADDR_WD;
   localparam int DW = c_DELAY_WD;
   localparam int HW = c_HPER_WD;
   localparam int NW = c_NCYC_WD;
   localparam int LW = DW + c_APOD_BITS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tx_delay_pulser_ch_if #(.ADDR_WD(AW), .DELAY_WD(DW), .HPER_WD(HW), .NCYC_WD(NW)) bus ();

   tx_delay_pulser_ch #(.ADDR_WD(AW), .DELAY_WD(DW), .HPER_WD(HW), .NCYC_WD(NW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Bench copy of the LUT
   int lut_d [256];
   bit lut_f [256];

   typedef struct {
      int line;
      int d;
      int h;
      int n;
      int exp_done;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   // Expected {pulse_p, pulse_n, tx_active, tx_done} t cycles after the start edge
   function automatic logic [3:0] model(input int t, input int d, input int h,
                                        input int n, input bit fe);
      int   he, ps, pe;
      logic p, m, a, dn;
      he = (h == 0) ? 1 : h;
      ps = 2 + d;
      pe = ps + 2 * he * n;
      p  = 1'b0;
      m  = 1'b0;
      a  = (t >= 1) && (t < pe);
      dn = (t == pe);
      if (fe && t >= ps && t < pe) begin
         if (((t - ps) / he) % 2 == 0) p = 1'b1;
         else                          m = 1'b1;
      end
      return {p, m, a, dn};
   endfunction

   function automatic logic [LW-1:0] pack(input int d, input bit fe);
      logic [LW-1:0] w;
      w = LW'(d);
      if (c_APOD_BITS != 0) w[LW-1] = fe;
      return w;
   endfunction

   function automatic logic [3:0] outs();
      return {bus.pulse_p, bus.pulse_n, bus.tx_active, bus.tx_done};
   endfunction

   task automatic lut_write(input int a, input int d, input bit fe);
      @(negedge clk);
      bus.lut_we   = 1'b1;
      bus.lut_addr = AW'(a);
      bus.lut_din  = pack(d, fe);
      @(posedge clk);
      #1 bus.lut_we = 1'b0;
      lut_d[a] = d;
      lut_f[a] = (c_APOD_BITS != 0) ? fe : 1'b1;
   endtask

   // Fire one line and compare every cycle against the model.
   // ab_e / st2_e: edge offsets (from the start edge) where abort / a second
   // start are sampled, -1 for none. rst_t: cycle at which rst_n is pulled.
   // wsame: write wdat/wfe to the fired line on the start edge.
   task automatic run_fire(input int line, input int h, input int n, input int d,
                           input bit fe, input int ab_e, input int st2_e,
                           input int rst_t, input bit wsame, input int wdat,
                           input bit wfe, output int done_off);
      int         he, last;
      logic [3:0] got, exp;
      he   = (h == 0) ? 1 : h;
      last = 2 + d + 2 * he * n + 3;
      if (ab_e >= 0 && ab_e + 5 > last) last = ab_e + 5;
      done_off = -1;
      @(negedge clk);
      bus.line_idx    = AW'(line);
      bus.half_period = HW'(h);
      bus.num_cycles  = NW'(n);
      bus.start       = 1'b1;
      if (wsame) begin
         bus.lut_we   = 1'b1;
         bus.lut_addr = AW'(line);
         bus.lut_din  = pack(wdat, wfe);
      end
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.lut_we = 1'b0;
      if (wsame) begin
         lut_d[line] = wdat;
         lut_f[line] = (c_APOD_BITS != 0) ? wfe : 1'b1;
      end
      for (int t = 0; t <= last; t++) begin
         @(negedge clk);
         got = outs();
         exp = (ab_e >= 0 && t >= ab_e) ? 4'b0000 : model(t, d, h, n, fe);
         if (got[0] === 1'b1 && done_off < 0) done_off = t;
         chk($sformatf("trace line=%0d D=%0d H=%0d N=%0d t=%0d {p,n,act,done}",
                       line, d, h, n, t), 32'(got), 32'(exp));
         bus.start = (st2_e >= 0 && t == st2_e - 1);
         bus.abort = (ab_e >= 0 && t == ab_e - 1);
         if (t == rst_t) begin
            #2 rst_n = 1'b0;
            #1 chk("async_reset_outputs", 32'(outs()), 32'h0);
            @(negedge clk);
            rst_n = 1'b1;
            break;
         end
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   initial begin
      vec_t tbl [6];
      int   done_off;
      int   line, d, h, n, he, ab_e, wdat;
      bit   fe, wsame, wfe;

      bus.lut_addr    = '0;
      bus.lut_we      = 1'b0;
      bus.lut_din     = '0;
      bus.line_idx    = '0;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.half_period = '0;
      bus.num_cycles  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'(outs()), 32'h0);
      rst_n = 1'b1;

      // Directed table: {line, D, H, N, expected tx_done offset}
      tbl[0] = '{5,   3, 2, 2, 13};
      tbl[1] = '{0,   0, 0, 1, 4};
      tbl[2] = '{1,   4, 2, 0, 6};
      tbl[3] = '{9,   1, 3, 1, 9};
      tbl[4] = '{20,  7, 1, 3, 15};
      tbl[5] = '{255, 0, 4, 2, 18};
      for (int i = 0; i < 6; i++) begin
         lut_write(tbl[i].line, tbl[i].d, 1'b1);
         run_fire(tbl[i].line, tbl[i].h, tbl[i].n, tbl[i].d, 1'b1,
                  -1, -1, -1, 1'b0, 0, 1'b0, done_off);
         chk($sformatf("done_offset vec%0d", i), 32'(done_off), 32'(tbl[i].exp_done));
      end

      // Abort mid pulse_n with an ignored second start, then refire
      run_fire(5, 2, 2, 3, 1'b1, 8, 5, -1, 1'b0, 0, 1'b0, done_off);
      chk("abort_no_done", 32'(done_off), 32'hffffffff);
      run_fire(5, 2, 2, 3, 1'b1, -1, -1, -1, 1'b0, 0, 1'b0, done_off);
      chk("refire_after_abort", 32'(done_off), 32'd13);

      // start and abort together in IDLE: nothing fires
      @(negedge clk);
      bus.line_idx = AW'(5);
      bus.start    = 1'b1;
      bus.abort    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         chk($sformatf("idle_abort_start t=%0d", t), 32'(outs()), 32'h0);
      end

      // Read-first: write 10 on the start edge, fire still uses the old 2
      lut_write(7, 2, 1'b1);
      run_fire(7, 1, 1, 2, 1'b1, -1, -1, -1, 1'b1, 10, 1'b1, done_off);
      chk("read_first_done", 32'(done_off), 32'd6);
      // Reset mid-DELAY on the new delay, then LUT must still hold 10
      run_fire(7, 1, 1, 10, 1'b1, -1, -1, 5, 1'b0, 0, 1'b0, done_off);
      run_fire(7, 1, 1, 10, 1'b1, -1, -1, -1, 1'b0, 0, 1'b0, done_off);
      chk("lut_kept_over_reset", 32'(done_off), 32'd14);

      // Muted element (fire enable clear when the mask bit exists)
      lut_write(3, 5, 1'b0);
      run_fire(3, 2, 2, 5, lut_f[3], -1, -1, -1, 1'b0, 0, 1'b0, done_off);
      chk("apod_done_timing", 32'(done_off), 32'd15);

      // Randomized fires against the model and the bench LUT copy
      for (int i = 0; i < 40; i++) begin
         line = int'($urandom_range(0, 255));
         d    = int'($urandom_range(0, 20));
         h    = int'($urandom_range(0, 4));
         n    = int'($urandom_range(0, 3));
         fe   = 1'($urandom_range(0, 1));
         lut_write(line, d, fe);
         he    = (h == 0) ? 1 : h;
         ab_e  = ($urandom_range(0, 3) == 0) ?
                 int'($urandom_range(1, 2 + d + 2 * he * n)) : -1;
         wsame = 1'($urandom_range(0, 1));
         wdat  = int'($urandom_range(0, 20));
         wfe   = 1'($urandom_range(0, 1));
         run_fire(line, h, n, lut_d[line], lut_f[line], ab_e, -1, -1,
                  wsame, wdat, wfe, done_off);
         if (wsame) begin
            run_fire(line, h, n, lut_d[line], lut_f[line], -1, -1, -1,
                     1'b0, 0, 1'b0, done_off);
            chk($sformatf("rand_followup_done i=%0d", i), 32'(done_off),
                32'(2 + lut_d[line] + 2 * he * n));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
